instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
- Registered RV32I/RV64I decode stage between fetch and register-file read.
- Decodes all six base formats (R, I, S, B, U, J) and produces a sign-extended, XLEN-wide immediate. B/J immediates are returned as full byte offsets.
- Flags illegal opcodes.
- Uses a valid/ready handshake on both sides, with a 2-entry skid buffer for full throughput under backpressure, and a flush input for branch redirect.

Parameters:
XLEN, 32, immediate and PC width; legal values 32 or 64
PC_W, XLEN, width of the PC carried alongside the instruction

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
flush_in  input  1  discard all buffered and incoming beats
valid_in  input  1  upstream beat valid
ready_out  output  1  stage can accept a beat
instr_in  input  32  instruction word
pc_in  input  PC_W  PC of instr_in
valid_out  output  1  decoded beat valid
ready_in  input  1  downstream accepts beat
pc_out  output  PC_W  PC of decoded beat
opcode_out  output  7  instr[6:0]
rd_out  output  5  destination register; 0 for S/B/illegal
rs1_out  output  5  source 1; 0 for U/J/illegal
rs2_out  output  5  source 2; 0 for I/U/J/illegal
funct3_out  output  3  instr[14:12]; 0 for U/J/illegal
funct7_out  output  7  instr[31:25] for R only, else 0
imm_out  output  XLEN  sign-extended immediate; 0 for R/illegal
fmt_out  output  3  0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
illegal_out  output  1  opcode unsupported or instr[1:0]!=2'b11

Behaviour:
Decode:
- Decode is combinational on instr_in and is captured at the accept edge.
- Opcode map:
  - R: 0110011.
  - I: 0000011, 0010011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Anything else is illegal.
- Immediates before sign extension:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- All immediates are sign-extended from bit instr[31] to XLEN. On XLEN=64, U-type is sign-extended from bit 31.
- Illegal beats are still passed downstream, with illegal_out=1, fmt_out=7, and every register/funct/imm field 0. opcode_out and pc_out are still valid.

Buffer:
- Two entries: main (drives outputs) and skid.
- ready_out = !skid_valid. It is a registered signal with no combinational path from ready_in.
- Accept when valid_in && ready_out && !flush_in.
- Transfer when valid_out && ready_in.
- Latency: beat accepted at edge N appears on valid_out after edge N (1 cycle) if main is empty or transferring.
- Each clock edge, in priority order:
  - flush_in=1: main_valid=0 and skid_valid=0. The incoming beat is dropped, even if valid_in=1.
  - Accept and (main empty or transfer): load into main. Simultaneous accept+transfer loses no cycle.
  - Accept, main full, no transfer: load into skid; ready_out drops next cycle.
  - Transfer and skid_valid: skid moves to main; skid clears; ready_out rises next cycle.
  - Transfer alone: main_valid=0.
- Ordering is strictly FIFO. No beat is duplicated or lost except by flush.
- Output fields hold stable while valid_out=1 && ready_in=0.

Reset:
- Asserted at any time, including mid-transfer: both entries are invalidated immediately.
- Reset values: valid_out=0, ready_out=1, all data outputs 0, fmt_out=0.
- First accept is allowed on the first edge after deassertion.

Test Plan:
- lw x5,8(x2), 0x00812283, pc 0x100, ready_in=1 -> one cycle later: valid_out=1, fmt=1, rd=5, rs1=2, funct3=2, imm=0x00000008, pc_out=0x100.
- beq x1,x2,-4, 0xFE208EE3 -> fmt=3, rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC. Then jal x1,2048, 0x001000EF -> fmt=5, rd=1, imm=0x00000800.
- lui x3,0x12345, 0x123451B7 -> fmt=4, rd=3, imm=0x12345000. Repeat with XLEN=64 and 0x800001B7 -> imm=0xFFFFFFFF80000000.
- 0x0000007F (unsupported opcode) and 0x00000013 with bits[1:0] forced to 00 -> illegal_out=1, fmt=7, all fields 0, beat still handshaken.
- Back-to-back stream of 8 beats; ready_in low for cycles 3-5:
  - ready_out drops exactly one cycle after skid fills.
  - Outputs hold stable during the stall.
  - All 8 beats appear in order.
  - Throughput returns to 1 beat/cycle afterwards.
- Flush with both entries full and valid_in=1 -> next cycle valid_out=0, ready_out=1, no stale beat emitted. Async reset pulsed mid-stall -> valid_out=0 immediately, outputs zero.

Source files
------------

// File: rtl/instr_decode_stage.sv
// RV32I/RV64I decode stage: combinational decode of the incoming word, captured
// into a 2-entry (main + skid) buffer with registered ready and flush support.
module instr_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            flush_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [PC_W-1:0] pc_out,
  output logic [6:0]      opcode_out,
  output logic [4:0]      rd_out,
  output logic [4:0]      rs1_out,
  output logic [4:0]      rs2_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      fmt_out,
  output logic            illegal_out
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
    FMT_U = 3'd4, FMT_J = 3'd5, FMT_X = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  fmt_e fmt;
  dec_t dec, main_q, skid_q;
  logic main_vld, skid_vld;
  logic acc, xfer;

  // Every legal opcode ends in 2'b11, so bad low bits fall into the default.
  always_comb begin
    fmt = FMT_X;
    case (instr_in[6:0])
      7'b0110011:                                     fmt = FMT_R;
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: fmt = FMT_I;
      7'b0100011:                                     fmt = FMT_S;
      7'b1100011:                                     fmt = FMT_B;
      7'b0110111, 7'b0010111:                         fmt = FMT_U;
      7'b1101111:                                     fmt = FMT_J;
      default:                                        fmt = FMT_X;
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.pc     = pc_in;
    dec.opcode = instr_in[6:0];
    dec.fmt    = fmt;
    case (fmt)
      FMT_R: begin
        dec.rd = instr_in[11:7]; dec.rs1 = instr_in[19:15]; dec.rs2 = instr_in[24:20];
        dec.funct3 = instr_in[14:12]; dec.funct7 = instr_in[31:25];
      end
      FMT_I: begin
        dec.rd = instr_in[11:7]; dec.rs1 = instr_in[19:15]; dec.funct3 = instr_in[14:12];
        dec.imm = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
      end
      FMT_S: begin
        dec.rs1 = instr_in[19:15]; dec.rs2 = instr_in[24:20]; dec.funct3 = instr_in[14:12];
        dec.imm = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      end
      FMT_B: begin
        dec.rs1 = instr_in[19:15]; dec.rs2 = instr_in[24:20]; dec.funct3 = instr_in[14:12];
        dec.imm = {{(XLEN-13){instr_in[31]}}, instr_in[31], instr_in[7],
                   instr_in[30:25], instr_in[11:8], 1'b0};
      end
      FMT_U: begin
        // Replicate from bit 31 so RV64 upper immediates sign-extend.
        dec.rd  = instr_in[11:7];
        dec.imm = {{(XLEN-31){instr_in[31]}}, instr_in[30:12], 12'b0};
      end
      FMT_J: begin
        dec.rd  = instr_in[11:7];
        dec.imm = {{(XLEN-21){instr_in[31]}}, instr_in[31], instr_in[19:12],
                   instr_in[20], instr_in[30:21], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign acc  = valid_in && !skid_vld && !flush_in;
  assign xfer = main_vld && ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush_in) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (acc && (!main_vld || xfer)) begin
      main_q   <= dec;
      main_vld <= 1'b1;
    end else if (acc) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end else if (xfer && skid_vld) begin
      main_q   <= skid_q;
      skid_vld <= 1'b0;
    end else if (xfer) begin
      main_vld <= 1'b0;
    end
  end

  assign ready_out   = !skid_vld;
  assign valid_out   = main_vld;
  assign pc_out      = main_q.pc;
  assign opcode_out  = main_q.opcode;
  assign rd_out      = main_q.rd;
  assign rs1_out     = main_q.rs1;
  assign rs2_out     = main_q.rs2;
  assign funct3_out  = main_q.funct3;
  assign funct7_out  = main_q.funct7;
  assign imm_out     = main_q.imm;
  assign fmt_out     = main_q.fmt;
  assign illegal_out = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: RV32 instance for all checks, RV64
// instance sharing the same stimulus for immediate sign-extension.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, vin, rdy_in;
  logic [31:0] instr, pc;
  logic [63:0] pc64;
  assign pc64 = {32'h0, pc};

  logic        rdy_out, vout, ill;
  logic [31:0] pc_o, imm;
  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3, fmt;

  logic        rdy_out64, vout64, ill64;
  logic [63:0] pc_o64, imm64;
  logic [6:0]  opc64, f7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64, fmt64;

  instr_decode_stage #(.XLEN(32)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(vin),
    .ready_out(rdy_out), .instr_in(instr), .pc_in(pc), .valid_out(vout),
    .ready_in(rdy_in), .pc_out(pc_o), .opcode_out(opc), .rd_out(rd),
    .rs1_out(rs1), .rs2_out(rs2), .funct3_out(f3), .funct7_out(f7),
    .imm_out(imm), .fmt_out(fmt), .illegal_out(ill)
  );

  instr_decode_stage #(.XLEN(64)) dut64 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(vin),
    .ready_out(rdy_out64), .instr_in(instr), .pc_in(pc64), .valid_out(vout64),
    .ready_in(rdy_in), .pc_out(pc_o64), .opcode_out(opc64), .rd_out(rd64),
    .rs1_out(rs1_64), .rs2_out(rs2_64), .funct3_out(f3_64), .funct7_out(f7_64),
    .imm_out(imm64), .fmt_out(fmt64), .illegal_out(ill64)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p);
    vin = 1'b1; instr = i; pc = p;
    step();
    vin = 1'b0;
  endtask

  task automatic chk_dec(input string t, input logic [31:0] epc, input logic [6:0] eopc,
                         input logic [2:0] efmt, input logic [4:0] erd, input logic [4:0] ers1,
                         input logic [4:0] ers2, input logic [2:0] ef3, input logic [6:0] ef7,
                         input logic [31:0] eimm, input logic eill);
    chk({t, ".vld"}, 64'(vout), 64'(1));
    chk({t, ".pc"},  64'(pc_o), 64'(epc));
    chk({t, ".opc"}, 64'(opc),  64'(eopc));
    chk({t, ".fmt"}, 64'(fmt),  64'(efmt));
    chk({t, ".rd"},  64'(rd),   64'(erd));
    chk({t, ".rs1"}, 64'(rs1),  64'(ers1));
    chk({t, ".rs2"}, 64'(rs2),  64'(ers2));
    chk({t, ".f3"},  64'(f3),   64'(ef3));
    chk({t, ".f7"},  64'(f7),   64'(ef7));
    chk({t, ".imm"}, 64'(imm),  64'(eimm));
    chk({t, ".ill"}, 64'(ill),  64'(eill));
  endtask

  initial begin
    int  i, nout;
    logic acc, xfer;
    rst_n = 1'b0; flush = 1'b0; vin = 1'b0; rdy_in = 1'b1; instr = '0; pc = '0;
    #3;
    chk("rst.vld", 64'(vout), 64'(0));
    chk("rst.rdy", 64'(rdy_out), 64'(1));
    chk("rst.imm", 64'(imm), 64'(0));
    chk("rst.fmt", 64'(fmt), 64'(0));
    chk("rst.pc",  64'(pc_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Decode: each beat transfers on the same edge the next one is accepted.
    send(32'h00812283, 32'h100);
    chk_dec("lw", 32'h100, 7'h03, 3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'h8, 1'b0);
    chk("lw.imm64", imm64, 64'h8);
    send(32'hFE208EE3, 32'h104);
    chk_dec("beq", 32'h104, 7'h63, 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0);
    chk("beq.imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
    send(32'h001000EF, 32'h108);
    chk_dec("jal", 32'h108, 7'h6F, 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1'b0);
    send(32'h123451B7, 32'h10C);
    chk_dec("lui", 32'h10C, 7'h37, 3'd4, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0);
    chk("lui.imm64", imm64, 64'h0000000012345000);
    send(32'h800001B7, 32'h110);
    chk_dec("luin", 32'h110, 7'h37, 3'd4, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h80000000, 1'b0);
    chk("luin.imm64", imm64, 64'hFFFFFFFF80000000);
    send(32'h402081B3, 32'h114);
    chk_dec("sub", 32'h114, 7'h33, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 1'b0);
    send(32'h00512423, 32'h118);
    chk_dec("sw", 32'h118, 7'h23, 3'd2, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'h8, 1'b0);
    send(32'h0000007F, 32'h11C);
    chk_dec("ill7f", 32'h11C, 7'h7F, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1);
    send(32'h00000010, 32'h120);
    chk_dec("ill10", 32'h120, 7'h10, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1);
    send(32'hFFFFFFFF, 32'h124);
    chk_dec("illff", 32'h124, 7'h7F, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1);
    step();
    chk("drain.vld", 64'(vout), 64'(0));

    // 8-beat stream, downstream stalled in cycles 3..5.
    i = 0; nout = 0;
    for (int c = 0; c < 13; c++) begin
      rdy_in = !(c >= 3 && c <= 5);
      vin    = (i < 8);
      instr  = (32'(i) << 20) | 32'h93;
      pc     = 32'h200 + 32'(4 * i);
      chk($sformatf("st%0d.rdy", c), 64'(rdy_out), 64'((c >= 4 && c <= 6) ? 0 : 1));
      chk($sformatf("st%0d.vld", c), 64'(vout), 64'((c >= 1 && c <= 11) ? 1 : 0));
      if (c >= 4 && c <= 6) chk($sformatf("st%0d.hold", c), 64'(pc_o), 64'h208);
      acc  = vin && rdy_out;
      xfer = vout && rdy_in;
      if (xfer) begin
        chk($sformatf("st.pc%0d", nout), 64'(pc_o), 64'(32'h200 + 32'(4 * nout)));
        chk($sformatf("st.imm%0d", nout), 64'(imm), 64'(nout));
        nout++;
      end
      step();
      if (acc) i++;
    end
    vin = 1'b0;
    chk("st.count", 64'(nout), 64'(8));

    // Flush with both entries full and a beat offered.
    rdy_in = 1'b0;
    send(32'h00100093, 32'h300);
    send(32'h00200093, 32'h304);
    chk("fl.full_rdy", 64'(rdy_out), 64'(0));
    flush = 1'b1; vin = 1'b1; instr = 32'h00300093; pc = 32'h308;
    step();
    flush = 1'b0; vin = 1'b0;
    chk("fl.vld", 64'(vout), 64'(0));
    chk("fl.rdy", 64'(rdy_out), 64'(1));
    rdy_in = 1'b1;
    step();
    chk("fl.stale", 64'(vout), 64'(0));

    // Async reset during a stall.
    rdy_in = 1'b0;
    send(32'h123451B7, 32'h400);
    chk("ar.pre", 64'(vout), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("ar.vld", 64'(vout), 64'(0));
    chk("ar.rdy", 64'(rdy_out), 64'(1));
    chk("ar.pc",  64'(pc_o), 64'(0));
    chk("ar.imm", 64'(imm), 64'(0));
    chk("ar.rd",  64'(rd), 64'(0));
    @(negedge clk);
    rst_n = 1'b1; rdy_in = 1'b1;
    send(32'h002081B3, 32'h500);
    chk_dec("add", 32'h500, 7'h33, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
